// File: rtl/qcs_pkg.sv
// Shared types and I-word field layout for the quantum control scheduler.
package qcs_pkg;

    localparam logic [1:0] ST_EMPTY   = 2'b00;
    localparam logic [1:0] ST_PENDING = 2'b10;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_1Q   = 2'b01,
        OP_2Q   = 2'b10,
        OP_MEAS = 2'b11
    } op_code_e;

    typedef enum logic {
        LD_IDLE  = 1'b0,
        LD_FLUSH = 1'b1
    } ld_state_e;

    function automatic int iw_width(input int qw);
        return 3 * qw + 20;
    endfunction

    function automatic int time_lsb(input int qw);
        return (qw > 0) ? 2 : 2;
    endfunction

    function automatic int dest_lsb(input int qw);
        return time_lsb(qw) + 16;
    endfunction

    function automatic int op2_lsb(input int qw);
        return dest_lsb(qw) + qw;
    endfunction

    function automatic int op1_lsb(input int qw);
        return op2_lsb(qw) + qw;
    endfunction

    function automatic int opc_lsb(input int qw);
        return op1_lsb(qw) + qw;
    endfunction

endpackage

// File: rtl/qcs_iword_pack.sv
// Combinational packer: decoded instruction fields -> pending I-word.
module qcs_iword_pack
    import qcs_pkg::*;
#(
    parameter int QW = 12,
    parameter int IW = 3 * QW + 20
) (
    input  logic [1:0]    op_code,
    input  logic [QW-1:0] op_1,
    input  logic [QW-1:0] op_2,
    input  logic [QW-1:0] dest,
    input  logic [15:0]   start_time,
    output logic [IW-1:0] iword
);

    localparam int T_LSB   = time_lsb(QW);
    localparam int D_LSB   = dest_lsb(QW);
    localparam int O2_LSB  = op2_lsb(QW);
    localparam int O1_LSB  = op1_lsb(QW);
    localparam int OPC_LSB = opc_lsb(QW);

    always_comb begin
        iword                   = '0;
        iword[1:0]              = ST_PENDING;
        iword[T_LSB +: 16]      = start_time;
        iword[D_LSB +: QW]      = dest;
        iword[O2_LSB +: QW]     = op_2;
        iword[O1_LSB +: QW]     = op_1;
        iword[OPC_LSB +: 2]     = op_code;
    end

endmodule

// File: rtl/qcs_instr_loader.sv
// Host-side writer of the scheduler's circular instruction array, with
// start_time ordering, consume tracking and a one-entry-per-cycle flush.
module qcs_instr_loader
    import qcs_pkg::*;
#(
    parameter int NUM_FPGA           = 64,
    parameter int NUM_QUBIT_PER_FPGA = 64,
    parameter int NUM_INSTRS         = 100,
    parameter int QW = $clog2(NUM_FPGA * NUM_QUBIT_PER_FPGA),
    parameter int IW = 3 * QW + 20,
    parameter int PW = $clog2(NUM_INSTRS),
    parameter int CW = $clog2(NUM_INSTRS + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [1:0]                        in_op_code,
    input  logic [QW-1:0]                     in_op_1,
    input  logic [QW-1:0]                     in_op_2,
    input  logic [QW-1:0]                     in_dest,
    input  logic [15:0]                       in_start_time,
    input  logic                              consume_valid,
    input  logic [PW-1:0]                     consume_idx,
    input  logic                              flush,
    output logic [0:NUM_INSTRS-1][IW-1:0]     instruction,
    output logic [NUM_INSTRS-1:0]             status,
    output logic [PW-1:0]                     wr_ptr,
    output logic [CW-1:0]                     count,
    output logic                              busy,
    output logic                              err_order,
    output logic                              err_consume
);

    ld_state_e     state, state_nxt;
    logic [PW-1:0] walk_idx;
    logic [15:0]   last_time;
    logic          seen_first;
    logic [IW-1:0] iword;

    logic xfer, order_bad, do_wr;
    logic idx_ok, cons_ok, cons_err;
    logic walk_last;

    qcs_iword_pack #(
        .QW(QW),
        .IW(IW)
    ) u_pack (
        .op_code    (in_op_code),
        .op_1       (in_op_1),
        .op_2       (in_op_2),
        .dest       (in_dest),
        .start_time (in_start_time),
        .iword      (iword)
    );

    always_comb begin
        status = '0;
        for (int i = 0; i < NUM_INSTRS; i++) begin
            status[i] = instruction[i][1];
        end
    end

    assign busy      = (state == LD_FLUSH);
    assign in_ready  = (state == LD_IDLE) && !instruction[wr_ptr][1];
    assign xfer      = in_valid && in_ready;
    assign order_bad = seen_first && (in_start_time < last_time);
    assign do_wr     = xfer && !order_bad;
    assign idx_ok    = int'(consume_idx) < NUM_INSTRS;
    assign cons_ok   = (state == LD_IDLE) && consume_valid
                       && idx_ok && status[consume_idx];
    assign cons_err  = (state == LD_IDLE) && consume_valid && !cons_ok;
    assign walk_last = (walk_idx == PW'(NUM_INSTRS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LD_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            LD_IDLE:  if (flush)     state_nxt = LD_FLUSH;
            LD_FLUSH: if (walk_last) state_nxt = LD_IDLE;
            default:                 state_nxt = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instruction <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            walk_idx    <= '0;
            last_time   <= '0;
            seen_first  <= 1'b0;
            err_order   <= 1'b0;
            err_consume <= 1'b0;
        end else begin
            err_order   <= xfer && order_bad;
            err_consume <= cons_err;
            if (state == LD_FLUSH) begin
                instruction[walk_idx] <= '0;
                if (walk_last) begin
                    walk_idx   <= '0;
                    wr_ptr     <= '0;
                    count      <= '0;
                    last_time  <= '0;
                    seen_first <= 1'b0;
                end else begin
                    walk_idx <= walk_idx + 1'b1;
                end
            end else begin
                // A write never targets an occupied entry, so it cannot
                // collide with the consume below.
                if (do_wr) begin
                    instruction[wr_ptr] <= iword;
                    wr_ptr     <= (wr_ptr == PW'(NUM_INSTRS - 1))
                                  ? '0 : wr_ptr + 1'b1;
                    last_time  <= in_start_time;
                    seen_first <= 1'b1;
                end
                if (cons_ok) instruction[consume_idx][1:0] <= ST_EMPTY;
                count <= count + CW'(do_wr) - CW'(cons_ok);
            end
        end
    end

endmodule

// File: doc/qcs_instr_loader.md
Name: qcs_instr_loader

Overview:
- Write side of the scheduler's instruction-array interface.
- Accepts decoded quantum instructions from the host over a valid/ready handshake and packs each into an I-word with status 2'b10.
- Writes I-words into a circular array of NUM_INSTRS entries that the scheduler scans, and frees an entry when the scheduler reports it consumed.
- Also enforces non-decreasing start_time order and provides a sequenced flush.

Parameters:
- NUM_FPGA, 64: FPGA count.
- NUM_QUBIT_PER_FPGA, 64: qubits per FPGA.
- NUM_INSTRS, 100: array depth; write pointer wraps at NUM_INSTRS-1.
- QW (derived), $clog2(NUM_FPGA*NUM_QUBIT_PER_FPGA): qubit index width (12 at defaults).
- IW (derived), 3*QW+20: I-word width (56 at defaults).

Ports:
- clk, in, 1: single clock.
- rst, in, 1: asynchronous, active-high reset.
- in_valid, in, 1: host presents an instruction.
- in_ready, out, 1: loader can accept this cycle.
- in_op_code, in, 2: operation code.
- in_op_1, in, QW: first operand qubit.
- in_op_2, in, QW: second operand qubit.
- in_dest, in, QW: destination qubit.
- in_start_time, in, 16: issue timestamp.
- consume_valid, in, 1: scheduler has taken an entry.
- consume_idx, in, $clog2(NUM_INSTRS): index of the consumed entry.
- flush, in, 1: request clear of the whole array.
- instruction, out, [0:NUM_INSTRS-1][IW-1:0]: registered instruction array.
- status, out, NUM_INSTRS: bit i = entry i occupied (mirrors instruction[i][1]).
- wr_ptr, out, $clog2(NUM_INSTRS): next entry to fill.
- count, out, $clog2(NUM_INSTRS+1): occupied entries.
- busy, out, 1: flush in progress.
- err_order, out, 1: one-cycle pulse, instruction rejected for start_time regression.
- err_consume, out, 1: one-cycle pulse, consume of an empty entry or an out-of-range index.

Behaviour:
- I-word packing: {op_code[IW-1:IW-2], op_1, op_2, dest[QW+17:18], start_time[17:2], status[1:0]=2'b10}; empty entry status = 2'b00.
- Reset: all instruction entries = 0; status = 0; wr_ptr = 0; count = 0; busy = 0; err_* = 0; last_time = 0; seen_first = 0; state = IDLE.
- FSM has two states.
  - IDLE: normal operation.
  - FLUSH: a walk index clears one entry per cycle, from 0 to NUM_INSTRS-1.
- Transfer occurs when in_valid && in_ready.
- in_ready = (state==IDLE) && !instruction[wr_ptr][1]. It is combinational from registers only, never from in_valid.
- Accepted write:
  - Lands at wr_ptr and is visible on instruction/status the next cycle (1-cycle latency).
  - wr_ptr advances; at NUM_INSTRS-1 it wraps to 0.
- Order check:
  - If seen_first && in_start_time < last_time, the transfer still completes (handshake consumed), but nothing is written and wr_ptr holds.
  - err_order pulses the following cycle.
  - Equal timestamps are legal.
  - On each successful write, last_time is set to in_start_time and seen_first is set to 1.
- Consume:
  - If status[consume_idx]==1, the entry's status bits are cleared to 2'b00 next cycle; the payload bits are left untouched.
  - If the entry is empty or consume_idx >= NUM_INSTRS, nothing changes and err_consume pulses.
- Simultaneous write and consume: write and consume cannot target the same index, since writes only go to free entries. Both take effect in the same cycle and count is unchanged.
- Full: count==NUM_INSTRS implies in_ready=0. Because of fill order, the array can also block while count<NUM_INSTRS when the entry at wr_ptr is still occupied (head-of-line). This is intended and matches the scheduler's in-order scan.
- Flush:
  - A flush seen in IDLE enters FLUSH the next cycle; busy=1 and in_ready=0.
  - Each cycle zeroes entry walk_idx (all IW bits).
  - After entry NUM_INSTRS-1 the FSM returns to IDLE with wr_ptr=0, count=0, seen_first=0 and last_time=0.
  - A flush takes NUM_INSTRS cycles.
  - consume_valid during FLUSH is ignored and raises no error.
  - flush asserted during FLUSH is ignored.
- Reset asserted mid-flush or mid-transfer restores all reset values immediately.
- count width must cover NUM_INSTRS. It never underflows, because error cases cause no decrement.

Decomposition:
- Package qcs_pkg holds:
  - I-word field offset functions parameterised by QW;
  - status encodings ST_EMPTY=2'b00 and ST_PENDING=2'b10;
  - the op_code enum (2 bits);
  - the loader FSM state typedef.
- Natural sub-module: qcs_iword_pack, a combinational field-to-I-word packer, reusable by the scheduler's decode.

Test Plan:
- Reset, then 3 writes with start_time 5, 5, 9 → entries 0..2 have status 2'b10; instruction[1][17:2]=5; wr_ptr=3; count=3; no errors.
- Write t=10 then t=7 → second transfer handshakes; err_order pulses 1 cycle; entry 1 stays empty; wr_ptr=1.
- Fill 100 entries → in_ready=0 and count=100. Consume idx 0 → entry 0 freed next cycle, in_ready=1; next write lands at 0 (wrap) and wr_ptr=1.
- With count=100, consume idx 50 → count=99 but in_ready stays 0 (wr_ptr=0 still occupied); then consume idx 0 → in_ready=1.
- Same-cycle write at wr_ptr=4 and consume idx 2 → count unchanged; status[4]=1, status[2]=0. Consume of empty idx 7 → err_consume pulse, count unchanged.
- Flush with 20 entries loaded → busy=1 for exactly 100 cycles; all entries 0; wr_ptr=0. Assert rst at flush cycle 30 → all outputs at reset values next edge.
